i2c_rtc_target: RTL and testbench
=================================

Name: i2c_rtc_target

Overview:
- I2C target (slave) that emulates a DS1307-style RTC register file at 7-bit address 0x68.
- Answers the on-board RTC read master and lets external I2C masters read the time; it is the responder end of the RTC read path.
- Holds NUM_REGS byte registers and an auto-incrementing register pointer. Local logic (the timekeeping counter) can overwrite registers through a side port.
- Sits between the board I2C pins and the time-counter/display logic.

Parameters:
- TARGET_ADDR, 7'h68, 7-bit I2C address the block acknowledges.
- NUM_REGS, 8, number of byte registers; must be a power of 2. PW = log2(NUM_REGS).

Ports:
- clk_50mhz  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- i2c_scl  in  1  bus clock; the target never stretches it.
- i2c_sda  inout  1  open-drain data; the block drives only 0 or z.
- loc_wr_en  in  1  local register write strobe.
- loc_wr_addr  in  PW  local write address.
- loc_wr_data  in  8  local write data.
- loc_rd_addr  in  PW  local read address.
- loc_rd_data  out  8  combinational read of regs[loc_rd_addr].
- bus_wr_stb  out  1  one-cycle pulse when an I2C data byte is committed.
- bus_wr_addr  out  PW  register address of the committed byte.
- bus_wr_data  out  8  committed byte.
- busy  out  1  high from an addressed START match until STOP.

Behaviour:
- Reset (async, rst_n=0) values:
  - all regs = 0, pointer = 0, state = IDLE.
  - SDA released (z), bus_wr_stb = 0, bus_wr_addr = 0, bus_wr_data = 0, busy = 0.
  - Synchronizer flops reset to 1.
- Input sampling:
  - SCL and SDA pass through 2-flop synchronizers plus one history flop.
  - Edges are detected on the synced values; event latency is 3 clk_50mhz cycles.
- Bus events:
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - START from any state, including a repeated start, goes to ADDR with bitcnt = 0.
  - STOP from any state goes to IDLE, releases SDA and clears busy.
- Bit timing:
  - Input bits are sampled on the SCL rising edge, MSB first.
  - The target changes its SDA drive only on a detected SCL falling edge.
- State machine:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits. On the 8th falling edge, if bits[7:1] == TARGET_ADDR, drive SDA=0, set busy and go to ADDR_ACK. Otherwise go to IDLE and ignore traffic until the next START.
  - ADDR_ACK: on the next falling edge release SDA.
    - R/W = 0: go to PTR.
    - R/W = 1: load shift register with regs[pointer], drive its MSB and go to READ.
  - PTR: shift 8 bits; on the 8th falling edge set pointer = byte[PW-1:0] (upper bits ignored), ACK and go to PTR_ACK.
  - PTR_ACK: release SDA on the next falling edge and go to WRITE.
  - WRITE: shift 8 bits. On the 8th rising edge:
    - write regs[pointer],
    - pulse bus_wr_stb with bus_wr_addr = pointer and bus_wr_data = byte,
    - increment pointer.
    Then ACK on the following falling edge and go to WRITE_ACK. WRITE_ACK releases SDA on the next falling edge and returns to WRITE. WRITE/WRITE_ACK repeat.
  - READ: drive bits 6..0 on successive falling edges. After the 8th bit's falling edge, release SDA, increment pointer and go to READ_ACK.
  - READ_ACK: sample SDA on the rising edge.
    - SDA = 0 (ACK): load regs[pointer] and drive its MSB on the next falling edge; go to READ.
    - SDA = 1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: ignore everything except START and STOP.
- Pointer:
  - Wraps from NUM_REGS-1 to 0. The pointer persists across transactions and STOP.
  - A read with no preceding PTR phase starts at the current pointer.
- Write collision: if I2C and local writes hit the same register in the same cycle, the I2C write wins. Local writes to other addresses proceed.
- Read consistency: read data is latched at byte load, so a local write during shifting does not corrupt the byte in flight.
- Reset mid-transfer: SDA is released immediately (async) and the block returns to IDLE.

Decomposition:
- Package i2c_rtc_pkg holds:
  - the state enum: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP,
  - the default TARGET_ADDR constant 7'h68.
- One sub-module, i2c_bus_sync: synchronizers plus edge and START/STOP detection. Outputs are scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
- Write 0x68+W, ptr 0x02, data 0x45, 0x13, STOP:
  - all three bytes ACKed,
  - regs[2] = 0x45 and regs[3] = 0x13,
  - two bus_wr_stb pulses at addresses 2 and 3,
  - pointer ends at 4.
- Write ptr 0x00, repeated START, 0x68+R, master ACKs 2 bytes then NACKs the third:
  - SDA carries regs[0], regs[1], regs[2] in that order,
  - SDA is released after the NACK,
  - busy falls at STOP.
- Address 0x50+W:
  - no ACK (SDA stays z for the whole transfer),
  - no register change, busy stays 0.
- Pointer 0x07, write 0xAA, 0xBB: regs[7] = 0xAA, regs[0] = 0xBB (wrap-around).
- Same-cycle local write 0x11 and I2C write 0x22 to reg 5: regs[5] = 0x22. A local write to reg 6 in that cycle is also applied.
- Assert rst_n while target drives an ACK low:
  - SDA released within the same cycle,
  - all regs and outputs at reset values,
  - the next transaction works normally.

Source files
------------

// File: rtl/i2c_rtc_pkg.sv
// Shared types and constants for the DS1307-style I2C RTC target.
package i2c_rtc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h68;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk_50mhz and flags SCL edges plus START/STOP.
module i2c_bus_sync (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // Stage boundary: p0/p1 are the synchroniser pair, p2 is the history flop.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign sda_s     = sda_p1;

endmodule

// File: rtl/i2c_rtc_target.sv
// I2C target exposing a small byte register file with an auto-incrementing pointer.
module i2c_rtc_target
  import i2c_rtc_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         NUM_REGS    = 8,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk_50mhz,
  input  logic          rst_n,
  input  logic          i2c_scl,
  inout  wire           i2c_sda,
  input  logic          loc_wr_en,
  input  logic [PW-1:0] loc_wr_addr,
  input  logic [7:0]    loc_wr_data,
  input  logic [PW-1:0] loc_rd_addr,
  output logic [7:0]    loc_rd_data,
  output logic          bus_wr_stb,
  output logic [PW-1:0] bus_wr_addr,
  output logic [7:0]    bus_wr_data,
  output logic          busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .scl       (i2c_scl),
    .sda       (i2c_sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  logic [7:0]    regs [NUM_REGS];
  i2c_state_e    state, state_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [PW-1:0] ptr, ptr_n;
  logic          sda_oe, sda_oe_n;
  logic          busy_n, rw, rw_n;
  logic          commit;
  logic [7:0]    commit_byte;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bitcnt <= 4'd0;
      shreg  <= 8'd0;
      ptr    <= '0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
      rw     <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      ptr    <= ptr_n;
      sda_oe <= sda_oe_n;
      busy   <= busy_n;
      rw     <= rw_n;
    end
  end

  // sda_oe = 1 pulls the line low; a 1 data bit is sent by releasing it.
  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    ptr_n       = ptr;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    rw_n        = rw;
    commit      = 1'b0;
    commit_byte = {shreg[6:0], sda_s};
    if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n  = ADDR;
      bitcnt_n = 4'd0;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ADDR, PTR: begin
          if (scl_rise) begin
            shreg_n  = {shreg[6:0], sda_s};
            bitcnt_n = bitcnt + 4'd1;
          end else if (scl_fall && bitcnt == 4'd8) begin
            if (state == PTR) begin
              ptr_n    = shreg[PW-1:0];
              sda_oe_n = 1'b1;
              state_n  = PTR_ACK;
            end else if (shreg[7:1] == TARGET_ADDR) begin
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              rw_n     = shreg[0];
              state_n  = ADDR_ACK;
            end else begin
              state_n = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw) begin
              sda_oe_n = 1'b0;
              bitcnt_n = 4'd0;
              state_n  = PTR;
            end else begin
              shreg_n  = regs[ptr];
              sda_oe_n = ~regs[ptr][7];
              bitcnt_n = 4'd1;
              state_n  = READ;
            end
          end
        end
        PTR_ACK, WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            bitcnt_n = 4'd0;
            state_n  = WRITE;
          end
        end
        WRITE: begin
          if (scl_rise) begin
            shreg_n  = {shreg[6:0], sda_s};
            bitcnt_n = bitcnt + 4'd1;
            if (bitcnt == 4'd7) begin
              commit = 1'b1;
              ptr_n  = ptr + 1'b1;
            end
          end else if (scl_fall && bitcnt == 4'd8) begin
            sda_oe_n = 1'b1;
            state_n  = WRITE_ACK;
          end
        end
        READ: begin
          if (scl_fall) begin
            if (bitcnt == 4'd8) begin
              sda_oe_n = 1'b0;
              ptr_n    = ptr + 1'b1;
              state_n  = READ_ACK;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
              bitcnt_n = bitcnt + 4'd1;
            end
          end
        end
        READ_ACK: begin
          // bitcnt = 9 marks "master acknowledged, reload on next falling edge".
          if (scl_rise) begin
            if (sda_s) state_n = WAIT_STOP;
            else       bitcnt_n = 4'd9;
          end else if (scl_fall && bitcnt == 4'd9) begin
            shreg_n  = regs[ptr];
            sda_oe_n = ~regs[ptr][7];
            bitcnt_n = 4'd1;
            state_n  = READ;
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_n = IDLE;
      endcase
    end
  end

  // Bus write is applied after the local write so it wins on an address clash.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
      bus_wr_stb  <= 1'b0;
      bus_wr_addr <= '0;
      bus_wr_data <= 8'd0;
    end else begin
      bus_wr_stb <= commit;
      if (commit) begin
        bus_wr_addr <= ptr;
        bus_wr_data <= commit_byte;
      end
      if (loc_wr_en) regs[loc_wr_addr] <= loc_wr_data;
      if (commit)    regs[ptr]         <= commit_byte;
    end
  end

  assign loc_rd_data = regs[loc_rd_addr];
  assign i2c_sda     = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_rtc_target.sv
// Directed bench for i2c_rtc_target: bit-banged I2C master plus local-port checks.
module tb_i2c_rtc_target;

  logic       clk_50mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       i2c_scl = 1'b1;
  logic       sda_drv = 1'b1;
  wire        i2c_sda;
  logic       loc_wr_en = 1'b0;
  logic [2:0] loc_wr_addr = 3'd0;
  logic [7:0] loc_wr_data = 8'd0;
  logic [2:0] loc_rd_addr = 3'd0;
  logic [7:0] loc_rd_data;
  logic       bus_wr_stb;
  logic [2:0] bus_wr_addr;
  logic [7:0] bus_wr_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int         stb_cnt = 0;
  logic [2:0] stb_addr [8];
  logic [7:0] stb_data [8];
  bit         watch_sda = 1'b0;
  int         sda_low_cnt = 0;

  assign i2c_sda = sda_drv ? 1'bz : 1'b0;
  pullup (i2c_sda);

  i2c_rtc_target dut (
    .clk_50mhz   (clk_50mhz),
    .rst_n       (rst_n),
    .i2c_scl     (i2c_scl),
    .i2c_sda     (i2c_sda),
    .loc_wr_en   (loc_wr_en),
    .loc_wr_addr (loc_wr_addr),
    .loc_wr_data (loc_wr_data),
    .loc_rd_addr (loc_rd_addr),
    .loc_rd_data (loc_rd_data),
    .bus_wr_stb  (bus_wr_stb),
    .bus_wr_addr (bus_wr_addr),
    .bus_wr_data (bus_wr_data),
    .busy        (busy)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  always @(negedge clk_50mhz) begin
    if (bus_wr_stb && stb_cnt < 8) begin
      stb_addr[stb_cnt] = bus_wr_addr;
      stb_data[stb_cnt] = bus_wr_data;
      stb_cnt++;
    end
  end

  always @(negedge clk_50mhz) begin
    #5;
    if (watch_sda && sda_drv && i2c_sda === 1'b0) sda_low_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  task automatic loc_write(input logic [2:0] a, input logic [7:0] d);
    loc_wr_addr = a;
    loc_wr_data = d;
    loc_wr_en   = 1'b1;
    wait_clk(1);
    loc_wr_en   = 1'b0;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_clk(4);
    i2c_scl = 1'b1;
    wait_clk(8);
    sda_drv = 1'b0;
    wait_clk(8);
    i2c_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clk(4);
    i2c_scl = 1'b1;
    wait_clk(8);
    sda_drv = 1'b1;
    wait_clk(8);
  endtask

  // Optionally fires a local write in the exact cycle the target commits the byte.
  task automatic i2c_write_byte(input logic [7:0] b, input bit loc_hit,
                                input logic [2:0] la, input logic [7:0] ld,
                                output bit acked);
    for (int i = 7; i >= 0; i--) begin
      wait_clk(4);
      sda_drv = b[i];
      wait_clk(4);
      i2c_scl = 1'b1;
      if (i == 0 && loc_hit) begin
        wait_clk(2);
        loc_wr_addr = la;
        loc_wr_data = ld;
        loc_wr_en   = 1'b1;
        wait_clk(1);
        loc_wr_en   = 1'b0;
        wait_clk(5);
      end else begin
        wait_clk(8);
      end
      i2c_scl = 1'b0;
    end
    wait_clk(4);
    sda_drv = 1'b1;
    wait_clk(4);
    i2c_scl = 1'b1;
    wait_clk(4);
    acked = (i2c_sda === 1'b0);
    wait_clk(4);
    i2c_scl = 1'b0;
  endtask

  task automatic i2c_read_byte(input bit mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'b1;
      wait_clk(8);
      i2c_scl = 1'b1;
      wait_clk(4);
      b[i] = (i2c_sda !== 1'b0);
      wait_clk(4);
      i2c_scl = 1'b0;
    end
    wait_clk(4);
    sda_drv = ~mack;
    wait_clk(4);
    i2c_scl = 1'b1;
    wait_clk(8);
    i2c_scl = 1'b0;
    wait_clk(1);
    sda_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (bus_wr_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b exp=0", bus_wr_stb); end
    total++; if (bus_wr_addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus_wr_addr); end
    total++; if (bus_wr_data !== 8'd0) begin bad++; $display("FAIL reset_data got=%h exp=00", bus_wr_data); end
    total++; if (i2c_sda === 1'b0) begin bad++; $display("FAIL reset_sda got=low exp=released"); end
    for (int k = 0; k < 8; k++) begin
      loc_rd_addr = 3'(k);
      #1;
      total++;
      if (loc_rd_data !== 8'd0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=00", k, loc_rd_data); end
    end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_write();
    logic [7:0] tx [4];
    logic [7:0] rd;
    bit ack;
    tx = '{8'hD0, 8'h02, 8'h45, 8'h13};
    loc_write(3'd4, 8'h5A);
    stb_cnt = 0;
    i2c_start();
    for (int k = 0; k < 4; k++) begin
      i2c_write_byte(tx[k], 1'b0, 3'd0, 8'd0, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL write_ack%0d got=%b exp=1", k, ack); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy got=%b exp=1", busy); end
    i2c_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
    loc_rd_addr = 3'd2; #1;
    total++; if (loc_rd_data !== 8'h45) begin bad++; $display("FAIL write_reg2 got=%h exp=45", loc_rd_data); end
    loc_rd_addr = 3'd3; #1;
    total++; if (loc_rd_data !== 8'h13) begin bad++; $display("FAIL write_reg3 got=%h exp=13", loc_rd_data); end
    total++; if (stb_cnt !== 2) begin bad++; $display("FAIL write_stb_cnt got=%0d exp=2", stb_cnt); end
    total++; if (stb_addr[0] !== 3'd2 || stb_data[0] !== 8'h45) begin bad++; $display("FAIL write_stb0 got=%0d/%h exp=2/45", stb_addr[0], stb_data[0]); end
    total++; if (stb_addr[1] !== 3'd3 || stb_data[1] !== 8'h13) begin bad++; $display("FAIL write_stb1 got=%0d/%h exp=3/13", stb_addr[1], stb_data[1]); end
    // Pointer should now be 4: a read with no pointer phase returns regs[4].
    i2c_start();
    i2c_write_byte(8'hD1, 1'b0, 3'd0, 8'd0, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL ptr4_ack got=%b exp=1", ack); end
    i2c_read_byte(1'b0, rd);
    total++; if (rd !== 8'h5A) begin bad++; $display("FAIL ptr4_read got=%h exp=5a", rd); end
    i2c_stop();
  endtask

  task automatic test_read();
    logic [7:0] exp_b [3];
    logic [7:0] rd;
    bit ack;
    exp_b = '{8'hC3, 8'h81, 8'h7E};
    for (int k = 0; k < 3; k++) loc_write(3'(k), exp_b[k]);
    i2c_start();
    i2c_write_byte(8'hD0, 1'b0, 3'd0, 8'd0, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL read_addrw_ack got=%b exp=1", ack); end
    i2c_write_byte(8'h00, 1'b0, 3'd0, 8'd0, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL read_ptr_ack got=%b exp=1", ack); end
    i2c_start();
    i2c_write_byte(8'hD1, 1'b0, 3'd0, 8'd0, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL read_addrr_ack got=%b exp=1", ack); end
    for (int k = 0; k < 3; k++) begin
      i2c_read_byte(k < 2, rd);
      total++; if (rd !== exp_b[k]) begin bad++; $display("FAIL read_byte%0d got=%h exp=%h", k, rd, exp_b[k]); end
    end
    wait_clk(6);
    total++; if (i2c_sda === 1'b0) begin bad++; $display("FAIL read_nack_release got=low exp=released"); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy got=%b exp=1", busy); end
    i2c_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_stop got=%b exp=0", busy); end
  endtask

  task automatic test_bad_addr();
    logic [7:0] tx [3];
    bit ack;
    tx = '{8'hA0, 8'h01, 8'h99};
    stb_cnt = 0;
    sda_low_cnt = 0;
    watch_sda = 1'b1;
    i2c_start();
    for (int k = 0; k < 3; k++) begin
      i2c_write_byte(tx[k], 1'b0, 3'd0, 8'd0, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL badaddr_ack%0d got=%b exp=0", k, ack); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL badaddr_busy got=%b exp=0", busy); end
    i2c_stop();
    watch_sda = 1'b0;
    total++; if (sda_low_cnt !== 0) begin bad++; $display("FAIL badaddr_sda_low got=%0d exp=0", sda_low_cnt); end
    total++; if (stb_cnt !== 0) begin bad++; $display("FAIL badaddr_stb got=%0d exp=0", stb_cnt); end
    loc_rd_addr = 3'd1; #1;
    total++; if (loc_rd_data !== 8'h81) begin bad++; $display("FAIL badaddr_reg1 got=%h exp=81", loc_rd_data); end
  endtask

  task automatic test_wrap();
    logic [7:0] tx [4];
    bit ack;
    tx = '{8'hD0, 8'h07, 8'hAA, 8'hBB};
    stb_cnt = 0;
    i2c_start();
    for (int k = 0; k < 4; k++) begin
      i2c_write_byte(tx[k], 1'b0, 3'd0, 8'd0, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL wrap_ack%0d got=%b exp=1", k, ack); end
    end
    i2c_stop();
    loc_rd_addr = 3'd7; #1;
    total++; if (loc_rd_data !== 8'hAA) begin bad++; $display("FAIL wrap_reg7 got=%h exp=aa", loc_rd_data); end
    loc_rd_addr = 3'd0; #1;
    total++; if (loc_rd_data !== 8'hBB) begin bad++; $display("FAIL wrap_reg0 got=%h exp=bb", loc_rd_data); end
    total++; if (stb_addr[1] !== 3'd0) begin bad++; $display("FAIL wrap_stb_addr got=%0d exp=0", stb_addr[1]); end
  endtask

  task automatic test_collision();
    bit ack0, ack1, ack2;
    i2c_start();
    i2c_write_byte(8'hD0, 1'b0, 3'd0, 8'd0, ack0);
    i2c_write_byte(8'h05, 1'b0, 3'd0, 8'd0, ack1);
    i2c_write_byte(8'h22, 1'b1, 3'd5, 8'h11, ack2);
    i2c_stop();
    total++; if ({ack0, ack1, ack2} !== 3'b111) begin bad++; $display("FAIL coll_acks got=%b exp=111", {ack0, ack1, ack2}); end
    loc_rd_addr = 3'd5; #1;
    total++; if (loc_rd_data !== 8'h22) begin bad++; $display("FAIL coll_same_reg5 got=%h exp=22", loc_rd_data); end
    i2c_start();
    i2c_write_byte(8'hD0, 1'b0, 3'd0, 8'd0, ack0);
    i2c_write_byte(8'h05, 1'b0, 3'd0, 8'd0, ack1);
    i2c_write_byte(8'h44, 1'b1, 3'd6, 8'h66, ack2);
    i2c_stop();
    loc_rd_addr = 3'd5; #1;
    total++; if (loc_rd_data !== 8'h44) begin bad++; $display("FAIL coll_other_reg5 got=%h exp=44", loc_rd_data); end
    loc_rd_addr = 3'd6; #1;
    total++; if (loc_rd_data !== 8'h66) begin bad++; $display("FAIL coll_other_reg6 got=%h exp=66", loc_rd_data); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    bit ack0, ack1, ack2;
    a = 8'hD0;
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      wait_clk(4);
      sda_drv = a[i];
      wait_clk(4);
      i2c_scl = 1'b1;
      wait_clk(8);
      i2c_scl = 1'b0;
    end
    wait_clk(4);
    sda_drv = 1'b1;
    #1;
    total++; if (i2c_sda !== 1'b0) begin bad++; $display("FAIL rstmid_ack_driven got=%b exp=0", i2c_sda); end
    rst_n = 1'b0;
    #1;
    total++; if (i2c_sda === 1'b0) begin bad++; $display("FAIL rstmid_sda_release got=low exp=released"); end
    wait_clk(2);
    total++; if ({busy, bus_wr_stb, bus_wr_addr, bus_wr_data} !== 13'd0) begin bad++; $display("FAIL rstmid_outputs got=%h exp=0", {busy, bus_wr_stb, bus_wr_addr, bus_wr_data}); end
    for (int k = 0; k < 8; k++) begin
      loc_rd_addr = 3'(k);
      #1;
      total++;
      if (loc_rd_data !== 8'd0) begin bad++; $display("FAIL rstmid_reg%0d got=%h exp=00", k, loc_rd_data); end
    end
    rst_n = 1'b1;
    wait_clk(4);
    i2c_scl = 1'b1;
    wait_clk(10);
    i2c_start();
    i2c_write_byte(8'hD0, 1'b0, 3'd0, 8'd0, ack0);
    i2c_write_byte(8'h01, 1'b0, 3'd0, 8'd0, ack1);
    i2c_write_byte(8'h3C, 1'b0, 3'd0, 8'd0, ack2);
    i2c_stop();
    total++; if ({ack0, ack1, ack2} !== 3'b111) begin bad++; $display("FAIL rstmid_after_acks got=%b exp=111", {ack0, ack1, ack2}); end
    loc_rd_addr = 3'd1; #1;
    total++; if (loc_rd_data !== 8'h3C) begin bad++; $display("FAIL rstmid_after_reg1 got=%h exp=3c", loc_rd_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_after_busy got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_addr();
    test_wrap();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
